// File: rtl/alu_pipe_seq_if.sv
// Operand/result handshake bundle for alu_pipe_seq.
// The master drives operand beats and result acceptance; the slave is the ALU pipe.
interface alu_pipe_seq_if #(
    parameter int WIDTH  = 64,
    parameter int IFUN_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IFUN_W-1:0] ifun;
    logic              set_cc;
    logic [WIDTH-1:0]  In1;
    logic [WIDTH-1:0]  In2;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  Out;
    logic              Overflow;
    logic              op_err;

    modport master (
        output in_valid, ifun, set_cc, In1, In2, out_ready,
        input  in_ready, out_valid, Out, Overflow, op_err
    );

    modport slave (
        input  in_valid, ifun, set_cc, In1, In2, out_ready,
        output in_ready, out_valid, Out, Overflow, op_err
    );
endinterface

// File: rtl/alu_pipe_seq.sv
// Two-stage pipelined Y86-64 OPq ALU (ADD/SUB/AND/XOR) with valid/ready flow control and ZF/SF/OF register.
// Optional sticky overflow flag with its own clear input when ALU_STICKY_OF_EN is defined.
module alu_pipe_seq #(
    parameter int WIDTH  = 64,
    parameter int IFUN_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_pipe_seq_if.slave bus,
`ifdef ALU_STICKY_OF_EN
    input  logic          of_clr,
    output logic          of_sticky,
`endif
    output logic          cc_zf,
    output logic          cc_sf,
    output logic          cc_of
);
    localparam logic [IFUN_W-1:0] FN_ADD = IFUN_W'(2'd0);
    localparam logic [IFUN_W-1:0] FN_SUB = IFUN_W'(2'd1);
    localparam logic [IFUN_W-1:0] FN_AND = IFUN_W'(2'd2);
    localparam logic [IFUN_W-1:0] FN_XOR = IFUN_W'(2'd3);

    // Signed overflow of b + a: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow of b - a (subq order): operands differ in sign, result sign leaves b's.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != b[WIDTH-1]);
    endfunction

    logic              r_s1_valid;
    logic [IFUN_W-1:0] r_s1_ifun;
    logic              r_s1_set_cc;
    logic [WIDTH-1:0]  r_s1_a;
    logic [WIDTH-1:0]  r_s1_b;

    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_out;
    logic              r_ovf;
    logic              r_err;

    logic              r_cc_zf;
    logic              r_cc_sf;
    logic              r_cc_of;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_cc_upd;
    logic [WIDTH-1:0]  w_res;
    logic              w_ovf;
    logic              w_err;

    // Stall chain: a stage may advance if it is empty or the stage after it advances.
    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_in_ready = w_s1_adv && rst_n;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Flags are only written by a legal, flag-setting beat as it leaves stage 1.
    assign w_cc_upd   = w_s2_adv && r_s1_valid && r_s1_set_cc && !w_err;

    // Stage-2 datapath evaluated on the stage-1 operands.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (r_s1_ifun)
            FN_ADD: begin
                w_res = r_s1_b + r_s1_a;
                w_ovf = add_ovf(r_s1_a, r_s1_b, w_res);
            end
            FN_SUB: begin
                w_res = r_s1_b - r_s1_a;
                w_ovf = sub_ovf(r_s1_a, r_s1_b, w_res);
            end
            FN_AND: begin
                w_res = r_s1_a & r_s1_b;
            end
            FN_XOR: begin
                w_res = r_s1_a ^ r_s1_b;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Stage 1: capture the operand beat when the handshake completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_ifun   <= {IFUN_W{1'b0}};
            r_s1_set_cc <= 1'b0;
            r_s1_a      <= {WIDTH{1'b0}};
            r_s1_b      <= {WIDTH{1'b0}};
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_ifun   <= bus.ifun;
                r_s1_set_cc <= bus.set_cc;
                r_s1_a      <= bus.In1;
                r_s1_b      <= bus.In2;
            end
        end
    end

    // Stage 2: register the result; data holds whenever the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= {WIDTH{1'b0}};
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_res;
                r_ovf <= w_ovf;
                r_err <= w_err;
            end
        end
    end

    // Condition codes track the most recent legal set_cc beat to enter stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cc_zf <= 1'b1;
            r_cc_sf <= 1'b0;
            r_cc_of <= 1'b0;
        end else if (w_cc_upd) begin
            r_cc_zf <= (w_res == {WIDTH{1'b0}});
            r_cc_sf <= w_res[WIDTH-1];
            r_cc_of <= w_ovf;
        end
    end

`ifdef ALU_STICKY_OF_EN
    logic r_of_sticky;

    // Sticky overflow: an accepted overflowing result sets it, taking priority over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_of_sticky <= 1'b0;
        end else if (r_s2_valid && bus.out_ready && r_ovf) begin
            r_of_sticky <= 1'b1;
        end else if (of_clr) begin
            r_of_sticky <= 1'b0;
        end
    end

    assign of_sticky = r_of_sticky;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.Out       = r_out;
    assign bus.Overflow  = r_ovf;
    assign bus.op_err    = r_err;
    assign cc_zf         = r_cc_zf;
    assign cc_sf         = r_cc_sf;
    assign cc_of         = r_cc_of;
endmodule
